// File: rtl/tile_drain_pkg.sv
// Shared defaults and types for the tile result drain.
// Holds the default widths/depth used by the interface, the top and the
// bench, plus the packed result record (scaled value + propagate tag).
package tile_drain_pkg;

  localparam int C_W_DEF     = 71;
  localparam int SHIFT_W_DEF = 5;
  localparam int OUT_W_DEF   = 32;
  localparam int DEPTH_DEF   = 4;

  typedef struct packed {
    logic signed [OUT_W_DEF-1:0] data;
    logic                        prop;
  } result_t;

endpackage

// File: rtl/tile_result_drain_if.sv
// Bus bundle between the compute tile, the drain and the result consumer.
//   in_c / in_valid / in_shift / in_propagate : tile -> drain (no backpressure)
//   out_bits / out_prop / out_valid           : drain -> consumer (FIFO head)
//   out_ready                                 : consumer -> drain
//   count / overflow                          : drain status
// master = tile/consumer side, slave = the drain itself.
interface tile_result_drain_if
  import tile_drain_pkg::*;
#(
  parameter int C_W     = C_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) ();

  logic signed [C_W-1:0]     in_c;
  logic                      in_valid;
  logic [SHIFT_W-1:0]        in_shift;
  logic                      in_propagate;
  logic signed [OUT_W-1:0]   out_bits;
  logic                      out_prop;
  logic                      out_valid;
  logic                      out_ready;
  logic [$clog2(DEPTH):0]    count;
  logic                      overflow;

  modport master (
    output in_c, in_valid, in_shift, in_propagate, out_ready,
    input  out_bits, out_prop, out_valid, count, overflow
  );

  modport slave (
    input  in_c, in_valid, in_shift, in_propagate, out_ready,
    output out_bits, out_prop, out_valid, count, overflow
  );

endinterface

// File: rtl/tile_result_drain_fifo.sv
// drain_fifo: synchronous FIFO for the tile result drain.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (pointers/count only)
//   i_wr_en/i_wr_data : write request and data
//   i_rd_en         : pop request (ignored while empty)
//   o_rd_data       : head entry, forced to 0 while empty
//   o_empty/o_full  : occupancy flags
//   o_count         : number of stored entries
// A write while full is accepted only when a pop frees the head slot in the
// same cycle; otherwise it is dropped and the contents stay untouched.
module drain_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr_en,
  input  logic [W-1:0]           i_wr_data,
  input  logic                   i_rd_en,
  output logic [W-1:0]           o_rd_data,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_rd_en && !w_empty;
  assign w_push  = i_wr_en && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; the empty mux below hides stale entries.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wr_data;
  end

  assign o_rd_data = w_empty ? '0 : r_mem[r_rptr];
  assign o_empty   = w_empty;
  assign o_full    = w_full;
  assign o_count   = r_count;

endmodule

// File: rtl/tile_result_drain.sv
// tile_result_drain: registers accumulator results from a compute tile,
// rounds (half toward +inf) and arithmetically right-shifts them by the
// per-result shift, saturates to OUT_W bits and queues them in a small FIFO
// for a ready/valid consumer.
// Ports:
//   clock : single clock, all state updates on its rising edge
//   reset : synchronous active-high reset, flushes pipeline and FIFO
//   bus   : tile_result_drain_if.slave (tile inputs, consumer handshake,
//           count and sticky overflow status)
module tile_result_drain
  import tile_drain_pkg::*;
#(
  parameter int C_W     = C_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input logic               clock,
  input logic               reset,
  tile_result_drain_if.slave bus
);

  localparam logic [C_W:0] ONE_X = {{C_W{1'b0}}, 1'b1};
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [C_W:0] SAT_MAX = {{(C_W+1-OUT_W){1'b0}}, OUT_MAX};
  localparam logic signed [C_W:0] SAT_MIN = {{(C_W+1-OUT_W){1'b1}}, OUT_MIN};

  // One extra bit keeps c + 2^(s-1) from wrapping. With s = 0 the bias is
  // zero, so the same expression also covers the unshifted case.
  function automatic logic signed [C_W:0] round_shift(
    input logic signed [C_W-1:0] c,
    input logic [SHIFT_W-1:0]    s
  );
    logic signed [C_W:0] ext;
    logic signed [C_W:0] bias;
    logic signed [C_W:0] sum;
    ext  = {c[C_W-1], c};
    bias = ONE_X << s;
    bias = bias >> 1;
    sum  = ext + bias;
    return sum >>> s;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(
    input logic signed [C_W:0] r
  );
    if (r > SAT_MAX)      return OUT_MAX;
    else if (r < SAT_MIN) return OUT_MIN;
    else                  return r[OUT_W-1:0];
  endfunction

  logic signed [C_W-1:0]   r_c_p1;
  logic [SHIFT_W-1:0]      r_shift_p1;
  logic                    r_prop_p1;
  logic                    r_vld_p1;
  logic                    r_overflow;

  logic signed [OUT_W-1:0] w_scaled_p2;
  logic [OUT_W:0]          w_wr_data_p2;
  logic [OUT_W:0]          w_head;
  logic                    w_empty;
  logic                    w_full;
  logic [$clog2(DEPTH):0]  w_count;

  // ---- stage 1: capture tile result ----
  always_ff @(posedge clock) begin
    if (reset) r_vld_p1 <= 1'b0;
    else       r_vld_p1 <= bus.in_valid;
  end

  always_ff @(posedge clock) begin
    r_c_p1     <= bus.in_c;
    r_shift_p1 <= bus.in_shift;
    r_prop_p1  <= bus.in_propagate;
  end

  // ---- stage 2: round, saturate, write FIFO tail ----
  assign w_scaled_p2  = saturate(round_shift(r_c_p1, r_shift_p1));
  assign w_wr_data_p2 = {r_prop_p1, w_scaled_p2};

  drain_fifo #(
    .DEPTH (DEPTH),
    .W     (OUT_W + 1)
  ) u_fifo (
    .clk       (clock),
    .rst       (reset),
    .i_wr_en   (r_vld_p1),
    .i_wr_data (w_wr_data_p2),
    .i_rd_en   (bus.out_ready),
    .o_rd_data (w_head),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_count   (w_count)
  );

  // A full FIFO is never empty, so out_ready alone tells whether the head
  // slot is freed in time to take the incoming write.
  always_ff @(posedge clock) begin
    if (reset)                                      r_overflow <= 1'b0;
    else if (r_vld_p1 && w_full && !bus.out_ready)  r_overflow <= 1'b1;
  end

  // ---- output: FIFO head ----
  assign bus.out_bits  = w_head[OUT_W-1:0];
  assign bus.out_prop  = w_head[OUT_W];
  assign bus.out_valid = !w_empty;
  assign bus.count     = w_count;
  assign bus.overflow  = r_overflow;

endmodule
